// File: rtl/mem_stage_dport_if.sv
// Bus bundle between the MEM-stage data-port controller, the EX_MEM register,
// the data cache and the hazard unit.
interface mem_stage_dport_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   mem_valid;
    logic                   mem_read;
    logic                   mem_write;
    logic [2:0]             funct3;
    logic [31:0]            addr;
    logic [31:0]            wdata;
    logic                   mem_advance;
    logic                   flush;
    logic                   dmem_read;
    logic                   dmem_write;
    logic [31:0]            dmem_address;
    logic [31:0]            dmem_wdata;
    logic [3:0]             dmem_mbe;
    logic                   dmem_resp;
    logic [31:0]            dmem_rdata;
    logic                   dmem_read_dp;
    logic                   data_resp_dp;
    logic [31:0]            load_data;
    logic                   mem_fault;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport slave (
        input  mem_valid, mem_read, mem_write, funct3, addr, wdata, mem_advance, flush,
        input  dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        output dmem_read_dp, data_resp_dp, load_data, mem_fault, stall_cycles
    );

    modport master (
        output mem_valid, mem_read, mem_write, funct3, addr, wdata, mem_advance, flush,
        output dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        input  dmem_read_dp, data_resp_dp, load_data, mem_fault, stall_cycles
    );
endinterface

// File: rtl/mem_stage_dport.sv
// MEM-stage data-port controller: latches one load/store, holds the cache request
// until dmem_resp, formats byte lanes and load data, and counts stall cycles.
module mem_stage_dport #(
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    mem_stage_dport_if.slave  bus_if
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            load_data_q, load_data_d;
    logic [2:0]             funct3_q, funct3_d;
    logic                   dir_q, dir_d;
    logic                   fault_q, fault_d;
    logic                   drop_q, drop_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   accept_s;
    logic                   bad_s;

    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic rd, input logic wr);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lo[0];
            3'b010:  bad = (lo != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | lo[0];
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [3:0] store_mbe(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = 4'b0011 << lo;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {lo, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Both-direction requests are accepted so they can be reported as faults.
    assign accept_s = bus_if.mem_valid & (bus_if.mem_read | bus_if.mem_write) & ~bus_if.flush;
    assign bad_s    = access_bad(bus_if.funct3, bus_if.addr[1:0], bus_if.mem_read, bus_if.mem_write);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
            funct3_q    <= 3'b000;
            dir_q       <= 1'b0;
            fault_q     <= 1'b0;
            drop_q      <= 1'b0;
            stall_q     <= {STALL_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            funct3_q    <= funct3_d;
            dir_q       <= dir_d;
            fault_q     <= fault_d;
            drop_q      <= drop_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        funct3_d    = funct3_q;
        dir_d       = dir_q;
        fault_d     = fault_q;
        drop_d      = drop_q;
        stall_d     = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d   = bus_if.addr;
                    wdata_d  = bus_if.wdata;
                    funct3_d = bus_if.funct3;
                    dir_d    = bus_if.mem_write;
                    drop_d   = 1'b0;
                    if (bad_s) begin
                        state_d     = ST_DONE;
                        fault_d     = 1'b1;
                        load_data_d = 32'h0000_0000;
                    end else begin
                        state_d = ST_REQ;
                        fault_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_d = (stall_q == {STALL_CNT_W{1'b1}}) ? stall_q
                        : stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
                // The cache cannot abort, so a flush only marks the result for discard.
                if (bus_if.dmem_resp) begin
                    drop_d = 1'b0;
                    if (drop_q | bus_if.flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DONE;
                        load_data_d = dir_q ? 32'h0000_0000
                                    : format_load(funct3_q, addr_q[1:0], bus_if.dmem_rdata);
                    end
                end else begin
                    drop_d = drop_q | bus_if.flush;
                end
            end
            ST_DONE: begin
                if (bus_if.flush | bus_if.mem_advance) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        bus_if.dmem_read    = 1'b0;
        bus_if.dmem_write   = 1'b0;
        bus_if.dmem_address = 32'h0000_0000;
        bus_if.dmem_wdata   = 32'h0000_0000;
        bus_if.dmem_mbe     = 4'b0000;
        bus_if.dmem_read_dp = 1'b0;
        bus_if.data_resp_dp = 1'b0;
        case (state_q)
            ST_IDLE: bus_if.dmem_read_dp = bus_if.mem_valid & bus_if.mem_read & ~bus_if.flush;
            ST_REQ: begin
                bus_if.dmem_read    = ~dir_q;
                bus_if.dmem_write   = dir_q;
                bus_if.dmem_address = {addr_q[31:2], 2'b00};
                bus_if.dmem_wdata   = wdata_q << {addr_q[1:0], 3'b000};
                bus_if.dmem_mbe     = dir_q ? store_mbe(funct3_q, addr_q[1:0]) : 4'b1111;
                bus_if.dmem_read_dp = ~dir_q;
            end
            ST_DONE: bus_if.data_resp_dp = 1'b1;
            default: bus_if.data_resp_dp = 1'b0;
        endcase
        bus_if.load_data    = load_data_q;
        bus_if.mem_fault    = fault_q & (state_q == ST_DONE);
        bus_if.stall_cycles = stall_q;
    end
endmodule

// File: tb/tb_mem_stage_dport.sv
// Directed plus randomized bench for mem_stage_dport against an arithmetic reference model.
module tb_mem_stage_dport;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_stall = 0;

    mem_stage_dport_if #(.STALL_CNT_W(16)) bus ();

    mem_stage_dport #(.STALL_CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mul(input logic [31:0] a);
        logic [31:0] m;
        m = 32'd1;
        for (int k = 0; k < int'(a % 32'd4); k++) m = m * 32'd256;
        return m;
    endfunction

    function automatic logic ref_legal(input logic rd_f, input logic wr_f, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (rd_f == wr_f) return 1'b0;
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return (a % 32'd2) == 32'd0;
            3'd2:    return (a % 32'd4) == 32'd0;
            3'd4:    return rd_f;
            3'd5:    return rd_f && ((a % 32'd2) == 32'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd / lane_mul(a);
        case (f3)
            3'd0:    return ((v % 32'd256) >= 32'd128) ? (v % 32'd256) - 32'd256 : v % 32'd256;
            3'd1:    return ((v % 32'd65536) >= 32'd32768) ? (v % 32'd65536) - 32'd65536 : v % 32'd65536;
            3'd4:    return v % 32'd256;
            3'd5:    return v % 32'd65536;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] ref_mbe(input logic rd_f, input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m;
        int size;
        int lane;
        if (rd_f) return 4'hF;
        size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        lane = int'(a % 32'd4);
        for (int b = 0; b < 4; b++) m[b] = (b >= lane) && (b < lane + size);
        return m;
    endfunction

    // Issue one op, serve it after `delay` REQ cycles, hold DONE `hold` cycles, then advance.
    task automatic run_op(input logic rd_f, input logic wr_f, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input logic [31:0] rd,
                          input int hold, input string tag);
        logic legal;
        logic stable;
        int rd_cyc;
        int wr_cyc;
        legal = ref_legal(rd_f, wr_f, f3, a);
        bus.mem_valid = 1'b1; bus.mem_read = rd_f; bus.mem_write = wr_f;
        bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        #1 check1({tag, "_dp_idle"}, bus.dmem_read_dp, rd_f);
        @(negedge clk);
        bus.mem_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.addr = $urandom; bus.wdata = $urandom; bus.funct3 = 3'($urandom_range(0, 7));
        if (legal) begin
            check32({tag, "_addr"}, bus.dmem_address, a - (a % 32'd4));
            check32({tag, "_mbe"}, 32'(bus.dmem_mbe), 32'(ref_mbe(rd_f, f3, a)));
            if (wr_f) check32({tag, "_wdata"}, bus.dmem_wdata, wd * lane_mul(a));
            check1({tag, "_dp_req"}, bus.dmem_read_dp, rd_f);
            rd_cyc = 0; wr_cyc = 0; stable = 1'b1;
            for (int i = 1; i <= delay; i++) begin
                if (bus.dmem_read) rd_cyc++;
                if (bus.dmem_write) wr_cyc++;
                if (bus.dmem_address !== a - (a % 32'd4) || bus.data_resp_dp !== 1'b0) stable = 1'b0;
                if (i == delay) begin
                    bus.dmem_resp = 1'b1; bus.dmem_rdata = rd;
                end
                @(negedge clk);
            end
            bus.dmem_resp = 1'b0; bus.dmem_rdata = $urandom;
            check32({tag, "_rd_cycles"}, 32'(rd_cyc), rd_f ? 32'(delay) : 32'd0);
            check32({tag, "_wr_cycles"}, 32'(wr_cyc), wr_f ? 32'(delay) : 32'd0);
            check1({tag, "_req_stable"}, stable, 1'b1);
            exp_stall = (exp_stall + delay > 65535) ? 65535 : exp_stall + delay;
            check1({tag, "_resp"}, bus.data_resp_dp, 1'b1);
            check1({tag, "_nofault"}, bus.mem_fault, 1'b0);
            if (rd_f) check32({tag, "_load"}, bus.load_data, ref_load(f3, a, rd));
        end else begin
            check1({tag, "_no_rd"}, bus.dmem_read, 1'b0);
            check1({tag, "_no_wr"}, bus.dmem_write, 1'b0);
            check1({tag, "_resp"}, bus.data_resp_dp, 1'b1);
            check1({tag, "_fault"}, bus.mem_fault, 1'b1);
            check32({tag, "_load0"}, bus.load_data, 32'd0);
        end
        check32({tag, "_stall"}, 32'(bus.stall_cycles), 32'(exp_stall));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.dmem_resp = (i == 1);
            @(negedge clk);
            if (bus.data_resp_dp !== 1'b1 || bus.dmem_read !== 1'b0 || bus.dmem_write !== 1'b0) stable = 1'b0;
        end
        bus.dmem_resp = 1'b0;
        if (hold > 0) check1({tag, "_done_hold"}, stable, 1'b1);
        bus.mem_advance = 1'b1;
        @(negedge clk);
        bus.mem_advance = 1'b0;
        check1({tag, "_idle"}, bus.data_resp_dp, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        logic        rl;
        rst_n = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'd0;
        bus.addr = 32'd0; bus.wdata = 32'd0; bus.mem_advance = 1'b0; bus.flush = 1'b0;
        bus.dmem_resp = 1'b0; bus.dmem_rdata = 32'd0;
        @(negedge clk);
        check1("rst_rd", bus.dmem_read, 1'b0);
        check1("rst_wr", bus.dmem_write, 1'b0);
        check32("rst_addr", bus.dmem_address, 32'd0);
        check32("rst_mbe", 32'(bus.dmem_mbe), 32'd0);
        check1("rst_resp", bus.data_resp_dp, 1'b0);
        check32("rst_load", bus.load_data, 32'd0);
        check32("rst_stall", 32'(bus.stall_cycles), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 3, 32'hDEADBEEF, 0, "lw");
        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1, 32'h80112233, 0, "lb");
        run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 2, 32'h80112233, 0, "lbu");
        run_op(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 1, 32'h80112233, 0, "lh");
        run_op(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000AB, 1, 32'd0, 0, "sb");
        run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000CAFE, 2, 32'd0, 0, "sh");
        run_op(1'b1, 1'b0, 3'd2, 32'h102, 32'd0, 1, 32'd0, 0, "lw_mis");
        run_op(1'b0, 1'b1, 3'd4, 32'h200, 32'd0, 1, 32'd0, 0, "sbu_ill");
        run_op(1'b1, 1'b0, 3'd3, 32'h200, 32'd0, 1, 32'd0, 0, "f3_ill");
        run_op(1'b1, 1'b1, 3'd2, 32'h200, 32'd0, 1, 32'd0, 0, "rdwr_ill");
        run_op(1'b1, 1'b0, 3'd2, 32'h104, 32'd0, 1, 32'h12345678, 4, "hold");

        // Flush in the second REQ cycle: request held until the response, then discarded.
        bus.mem_valid = 1'b1; bus.mem_read = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h300;
        @(negedge clk);
        bus.mem_valid = 1'b0; bus.mem_read = 1'b0;
        check1("fl_req1", bus.dmem_read, 1'b1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check1("fl_held", bus.dmem_read, 1'b1);
        check1("fl_noresp", bus.data_resp_dp, 1'b0);
        bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        bus.dmem_resp = 1'b0;
        check1("fl_rd_off", bus.dmem_read, 1'b0);
        check1("fl_dropped", bus.data_resp_dp, 1'b0);
        @(negedge clk);
        check1("fl_dropped2", bus.data_resp_dp, 1'b0);
        exp_stall = exp_stall + 3;
        check32("fl_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rf = 3'($urandom_range(0, 7));
            rl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_op(rl, ~rl, rf, ra, $urandom, $urandom_range(1, 4), $urandom, 0, "rnd");
        end

        run_op(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 65600, 32'hA5A5A5A5, 0, "sat");

        // Asynchronous reset in the middle of a request.
        bus.mem_valid = 1'b1; bus.mem_read = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h500;
        @(negedge clk);
        bus.mem_valid = 1'b0; bus.mem_read = 1'b0;
        check1("ar_req", bus.dmem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1 check1("ar_rd_off", bus.dmem_read, 1'b0);
        check32("ar_stall", 32'(bus.stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        @(negedge clk);
        check1("ar_idle", bus.dmem_read, 1'b0);
        run_op(1'b1, 1'b0, 3'd5, 32'h502, 32'd0, 1, 32'h8001FFFF, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
